// File: rtl/bitstream_reader_if.sv
// bitstream_reader_if: word input, consume/align requests
// and the bit window presented back to the parser.
interface bitstream_reader_if;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;
  logic        consume;
  logic [5:0]  consume_len;
  logic        align;
  logic [31:0] window;
  logic [6:0]  avail;
  logic [2:0]  bitpos;
  logic        err;

  modport master (
    output ivalid,
    output idata,
    output consume,
    output consume_len,
    output align,
    input  iready,
    input  window,
    input  avail,
    input  bitpos,
    input  err
  );

  modport slave (
    input  ivalid,
    input  idata,
    input  consume,
    input  consume_len,
    input  align,
    output iready,
    output window,
    output avail,
    output bitpos,
    output err
  );
endinterface

// File: rtl/bitstream_reader.sv
// bitstream_reader: unpacks 32-bit words into a left-justified
// 64-bit bit buffer consumed 0..32 bits/cycle by the parser.
module bitstream_reader #(
  parameter bit ERR_FATAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  bitstream_reader_if.slave bs
);

  logic [63:0] buf_q, buf_d;
  logic [6:0]  avail_q, avail_d;
  logic [2:0]  bitpos_q, bitpos_d;
  logic        err_q, err_d;
  logic        iready_q;

  logic        accept;
  logic        bad_len;
  logic        bad_align;
  logic        illegal;
  logic [2:0]  k;
  logic [5:0]  rem;
  logic [6:0]  avail_r;
  logic [63:0] buf_r;
  logic [63:0] ins;

  assign bs.window = buf_q[63:32];
  assign bs.avail  = avail_q;
  assign bs.bitpos = bitpos_q;
  assign bs.err    = err_q;
  assign bs.iready = iready_q;

  // Classify this cycle's request and form the next buffer.
  always_comb begin
    accept    = bs.ivalid && iready_q;
    k         = 3'd0 - bitpos_q;
    bad_len   = (bs.consume_len > 6'd32) ||
                ({1'b0, bs.consume_len} > avail_q);
    bad_align = {4'b0, k} > avail_q;
    illegal   = (bs.consume && bs.align) ||
                (bs.consume && bad_len) ||
                (bs.align && bad_align);
    rem       = 6'd0;
    bitpos_d  = bitpos_q;
    if (!illegal) begin
      if (bs.consume) begin
        rem      = bs.consume_len;
        bitpos_d = bitpos_q + bs.consume_len[2:0];
      end else if (bs.align) begin
        rem      = {3'b0, k};
        bitpos_d = 3'd0;
      end
    end
    buf_r   = buf_q << rem;
    avail_r = avail_q - {1'b0, rem};
    ins     = {bs.idata, 32'b0} >> avail_r;
    buf_d   = buf_r;
    avail_d = avail_r;
    if (accept) begin
      buf_d   = buf_r | ins;
      avail_d = avail_r + 7'd32;
    end
    err_d = err_q || illegal;
  end

  // Buffer, counters, sticky error and registered iready.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      avail_q  <= '0;
      bitpos_q <= '0;
      err_q    <= 1'b0;
      iready_q <= 1'b1;
    end else begin
      buf_q    <= buf_d;
      avail_q  <= avail_d;
      bitpos_q <= bitpos_d;
      err_q    <= err_d;
      iready_q <= avail_d <= 7'd32;
    end
  end

  // Optional hard stop in simulation on a protocol error.
  if (ERR_FATAL) begin : g_fatal
    always_ff @(posedge clk) begin
      if (!rst && illegal)
        $fatal(1, "bitstream_reader: protocol error");
    end
  end

endmodule

// File: tb/tb_bitstream_reader.sv
// tb_bitstream_reader: directed scoreboard bench; driver
// queues expected state, monitor compares on negedge.
module tb_bitstream_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int          cyc;
    logic [31:0] win;
    logic [6:0]  av;
    logic [2:0]  bp;
    logic        er;
    logic        rdy;
  } exp_t;

  exp_t q[$];

  bitstream_reader_if bs ();

  bitstream_reader #(.ERR_FATAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bs  (bs.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [31:0] w,
                      input logic [6:0] a,
                      input logic [2:0] b,
                      input logic e);
    exp_t x;
    x.cyc = cyc + 1;
    x.win = w;
    x.av  = a;
    x.bp  = b;
    x.er  = e;
    x.rdy = (a <= 7'd32);
    q.push_back(x);
  endtask

  task automatic drive(input logic r,
                       input logic v,
                       input logic [31:0] d,
                       input logic c,
                       input logic [5:0] l,
                       input logic al);
    @(posedge clk);
    #1;
    rst            = r;
    bs.ivalid      = v;
    bs.idata       = d;
    bs.consume     = c;
    bs.consume_len = l;
    bs.align       = al;
  endtask

  task automatic step(input logic v,
                      input logic [31:0] d,
                      input logic c,
                      input logic [5:0] l,
                      input logic al,
                      input logic [31:0] w,
                      input logic [6:0] a,
                      input logic [2:0] b,
                      input logic e);
    drive(1'b0, v, d, c, l, al);
    push(w, a, b, e);
  endtask

  task automatic do_reset(input logic v,
                          input logic [31:0] d);
    drive(1'b1, v, d, 1'b0, 6'd0, 1'b0);
    push(32'h0, 7'd0, 3'd0, 1'b0);
  endtask

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, act, req);
    end
  endtask

  // Monitor: compare DUT state against the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      if (x.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed cyc %0d: got %0d want %0d",
                 x.cyc, cyc, x.cyc);
      end else begin
        cmp("window", bs.window, x.win);
        cmp("avail", {25'b0, bs.avail}, {25'b0, x.av});
        cmp("bitpos", {29'b0, bs.bitpos}, {29'b0, x.bp});
        cmp("err", {31'b0, bs.err}, {31'b0, x.er});
        cmp("iready", {31'b0, bs.iready}, {31'b0, x.rdy});
      end
    end
  end

  initial begin
    logic [31:0] w;
    bs.ivalid      = 1'b0;
    bs.idata       = '0;
    bs.consume     = 1'b0;
    bs.consume_len = '0;
    bs.align       = 1'b0;

    // reset drops the word offered in the same cycle
    do_reset(1'b1, 32'hCAFEF00D);
    step(1, 32'hFFD8FFE0, 0, 0, 0,
         32'hFFD8FFE0, 7'd32, 3'd0, 0);

    // fill, consume 4, align, align no-op
    do_reset(0, 0);
    step(1, 32'hAABBCCDD, 0, 0, 0,
         32'hAABBCCDD, 7'd32, 3'd0, 0);
    step(1, 32'h11223344, 0, 0, 0,
         32'hAABBCCDD, 7'd64, 3'd0, 0);
    step(0, 0, 1, 6'd4, 0,
         32'hABBCCDD1, 7'd60, 3'd4, 0);
    step(0, 0, 0, 0, 1,
         32'hBBCCDD11, 7'd56, 3'd0, 0);
    step(0, 0, 0, 0, 1,
         32'hBBCCDD11, 7'd56, 3'd0, 0);
    // word offered while full is ignored
    step(1, 32'hDEADDEAD, 0, 0, 0,
         32'hBBCCDD11, 7'd56, 3'd0, 0);
    // drop to 32: iready rises next cycle
    step(0, 0, 1, 6'd24, 0,
         32'h11223344, 7'd32, 3'd0, 0);
    // partial consume with same-cycle accept
    step(1, 32'h55667788, 1, 6'd8, 0,
         32'h22334455, 7'd56, 3'd0, 0);

    // streaming at 32 bits/cycle
    do_reset(0, 0);
    step(1, 32'h12345678, 0, 0, 0,
         32'h12345678, 7'd32, 3'd0, 0);
    step(1, 32'h9ABCDEF0, 1, 6'd32, 0,
         32'h9ABCDEF0, 7'd32, 3'd0, 0);
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      step(1, w, 1, 6'd32, 0, w, 7'd32, 3'd0, 0);
    end

    // protocol errors
    do_reset(0, 0);
    step(1, 32'h12345678, 0, 0, 0,
         32'h12345678, 7'd32, 3'd0, 0);
    step(0, 0, 1, 6'd24, 0,
         32'h78000000, 7'd8, 3'd0, 0);
    step(0, 0, 1, 6'd9, 0,
         32'h78000000, 7'd8, 3'd0, 1);
    step(0, 0, 1, 6'd1, 1,
         32'h78000000, 7'd8, 3'd0, 1);
    // illegal request with accept: word still lands
    step(1, 32'hA1B2C3D4, 1, 6'd33, 0,
         32'h78A1B2C3, 7'd40, 3'd0, 1);
    do_reset(0, 0);

    // mid-stream reset with a word offered
    step(1, 32'h12345678, 0, 0, 0,
         32'h12345678, 7'd32, 3'd0, 0);
    step(0, 0, 1, 6'd5, 0,
         32'h468ACF00, 7'd27, 3'd5, 0);
    step(0, 0, 1, 6'd7, 0,
         32'h45678000, 7'd20, 3'd4, 0);
    do_reset(1, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0,
         32'h0, 7'd0, 3'd0, 0);
    // empty: zero-length requests are legal
    step(0, 0, 1, 6'd0, 0,
         32'h0, 7'd0, 3'd0, 0);
    step(0, 0, 0, 0, 1,
         32'h0, 7'd0, 3'd0, 0);
    step(0, 0, 1, 6'd1, 0,
         32'h0, 7'd0, 3'd0, 1);

    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
